// File: rtl/ctrl_sequencer.sv
// Hardwired fetch / register-to-register ALU execute sequencer for the DataPath.
// Optional STEP_MODE_EN adds a `step` input that gates every non-IDLE transition.
//
// state | meaning
// IDLE  | waiting for start, no strobes
// T0    | PC -> MAR, Z <= PC+1
// T1    | first memory-read cycle, Z -> PC, MDR <= mem
// T1W   | memory wait, MDR keeps loading, no PC load
// T2    | MDR -> IR
// T3    | Rb -> Y, or flag illegal opcode
// T4    | Rc op Y -> Z, holds while ALU busy
// T5    | Zlo -> Ra (or LO for MUL/DIV)
// T6    | Zhi -> HI (MUL/DIV only)
module ctrl_sequencer #(
  parameter int SEL_W    = 32,
  parameter int NUM_GPR  = 16,
  parameter int HI_IDX   = 16,
  parameter int LO_IDX   = 17,
  parameter int ZHI_IDX  = 18,
  parameter int ZLO_IDX  = 19,
  parameter int PC_IDX   = 20,
  parameter int MDR_IDX  = 21,
  parameter int ALU_W    = 16,
  parameter int INCPC_OP = 20,
  parameter int MUL_OPC  = 15,
  parameter int DIV_OPC  = 16,
  parameter int OP_LIMIT = 19
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             start,
  input  logic             halt,
  input  logic [31:0]      ir,
  input  logic             mem_ready,
  input  logic             alu_busy,
`ifdef STEP_MODE_EN
  input  logic             step,
`endif
  output logic [SEL_W-1:0] Rin,
  output logic [SEL_W-1:0] Rout,
  output logic             IRin,
  output logic             MARin,
  output logic             RYin,
  output logic             MDRread,
  output logic [ALU_W-1:0] ALUControl,
  output logic             busy,
  output logic             done,
  output logic             illegal
);

  typedef enum logic [3:0] {
    S_IDLE, S_T0, S_T1, S_T1W, S_T2, S_T3, S_T4, S_T5, S_T6
  } state_t;

  localparam logic [SEL_W-1:0] ONE     = {{(SEL_W-1){1'b0}}, 1'b1};
  localparam logic [SEL_W-1:0] SEL_HI  = ONE << HI_IDX;
  localparam logic [SEL_W-1:0] SEL_LO  = ONE << LO_IDX;
  localparam logic [SEL_W-1:0] SEL_ZHI = ONE << ZHI_IDX;
  localparam logic [SEL_W-1:0] SEL_ZLO = ONE << ZLO_IDX;
  localparam logic [SEL_W-1:0] SEL_PC  = ONE << PC_IDX;
  localparam logic [SEL_W-1:0] SEL_MDR = ONE << MDR_IDX;

  state_t      state;
  logic        adv;
  logic [4:0]  opcode;
  logic [3:0]  ra, rb, rc;
  logic        is_muldiv;
  logic        op_bad;
  logic        unused_ir;

  assign opcode    = ir[31:27];
  assign ra        = ir[26:23];
  assign rb        = ir[22:19];
  assign rc        = ir[18:15];
  assign unused_ir = ^ir[14:0];
  assign is_muldiv = (opcode == 5'(MUL_OPC)) || (opcode == 5'(DIV_OPC));
  assign op_bad    = {27'd0, opcode} >= 32'(OP_LIMIT);

`ifdef STEP_MODE_EN
  assign adv = step;
`else
  assign adv = 1'b1;
`endif

  // Out-of-range register indices decode to no strobe at all.
  function automatic logic [SEL_W-1:0] gpr_sel(input logic [3:0] r);
    return ({28'd0, r} < 32'(NUM_GPR)) ? (ONE << r) : '0;
  endfunction

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state   <= S_IDLE;
      illegal <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (start) state <= S_T0;
        S_T0:   if (adv) state <= S_T1;
        S_T1, S_T1W:
          if (adv) state <= mem_ready ? S_T2 : S_T1W;
        S_T2:   if (adv) state <= S_T3;
        S_T3:
          if (adv) begin
            if (op_bad) begin
              illegal <= 1'b1;
              state   <= S_IDLE;
            end else begin
              state <= S_T4;
            end
          end
        S_T4:   if (adv && !alu_busy) state <= S_T5;
        S_T5:
          if (adv) begin
            if (is_muldiv) state <= S_T6;
            else           state <= halt ? S_IDLE : S_T0;
          end
        S_T6:   if (adv) state <= halt ? S_IDLE : S_T0;
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    Rin        = '0;
    Rout       = '0;
    IRin       = 1'b0;
    MARin      = 1'b0;
    RYin       = 1'b0;
    MDRread    = 1'b0;
    ALUControl = '0;
    done       = 1'b0;
    busy       = (state != S_IDLE);
    case (state)
      S_T0: begin
        Rout       = SEL_PC;
        MARin      = 1'b1;
        Rin        = SEL_ZLO;
        ALUControl = ALU_W'(INCPC_OP);
      end
      S_T1: begin
        Rout    = SEL_ZLO;
        Rin     = SEL_PC | SEL_MDR;
        MDRread = 1'b1;
      end
      S_T1W: begin
        Rout    = SEL_ZLO;
        Rin     = SEL_MDR;
        MDRread = 1'b1;
      end
      S_T2: begin
        Rout = SEL_MDR;
        IRin = 1'b1;
      end
      S_T3: begin
        if (!op_bad) begin
          Rout = gpr_sel(rb);
          RYin = 1'b1;
        end
      end
      S_T4: begin
        Rout       = gpr_sel(rc);
        ALUControl = ALU_W'(opcode);
        Rin        = SEL_ZLO;
      end
      S_T5: begin
        Rout = SEL_ZLO;
        Rin  = is_muldiv ? SEL_LO : gpr_sel(ra);
        done = !is_muldiv;
      end
      S_T6: begin
        Rout = SEL_ZHI;
        Rin  = SEL_HI;
        done = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Directed bench for ctrl_sequencer: fetch, ALU, MUL, waits, illegal, back-to-back, reset.
module tb_ctrl_sequencer;

  logic        clock = 1'b0;
  logic        clear = 1'b0;
  logic        start = 1'b0;
  logic        halt  = 1'b1;
  logic [31:0] ir    = 32'h0;
  logic        mem_ready = 1'b1;
  logic        alu_busy  = 1'b0;
  logic [31:0] Rin, Rout;
  logic        IRin, MARin, RYin, MDRread;
  logic [15:0] ALUControl;
  logic        busy, done, illegal;

  int n_cmp = 0;
  int n_bad = 0;
  int busy_cyc = 0;

  localparam logic [31:0] R16 = 32'h0001_0000;
  localparam logic [31:0] R17 = 32'h0002_0000;
  localparam logic [31:0] R18 = 32'h0004_0000;
  localparam logic [31:0] R19 = 32'h0008_0000;
  localparam logic [31:0] R20 = 32'h0010_0000;
  localparam logic [31:0] R21 = 32'h0020_0000;
  localparam logic [6:0] F_IR   = 7'b1000000;
  localparam logic [6:0] F_MAR  = 7'b0100000;
  localparam logic [6:0] F_RY   = 7'b0010000;
  localparam logic [6:0] F_MDR  = 7'b0001000;
  localparam logic [6:0] F_BUSY = 7'b0000100;
  localparam logic [6:0] F_DONE = 7'b0000010;
  localparam logic [6:0] F_ILL  = 7'b0000001;
  localparam logic [31:0] IR_SHRA = 32'h5B82_0000;
  localparam logic [31:0] IR_MUL  = 32'h781A_8000;
  localparam logic [31:0] IR_BAD  = 32'hC800_0000;

  ctrl_sequencer dut (
    .clock(clock), .clear(clear), .start(start), .halt(halt), .ir(ir),
    .mem_ready(mem_ready), .alu_busy(alu_busy),
    .Rin(Rin), .Rout(Rout), .IRin(IRin), .MARin(MARin), .RYin(RYin),
    .MDRread(MDRread), .ALUControl(ALUControl), .busy(busy), .done(done),
    .illegal(illegal)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic exp_cyc(input string tag, input logic [31:0] rin, input logic [31:0] rout,
                         input logic [31:0] alu, input logic [6:0] fl);
    chk({tag, ".Rin"}, Rin, rin);
    chk({tag, ".Rout"}, Rout, rout);
    chk({tag, ".alu"}, {16'd0, ALUControl}, alu);
    chk({tag, ".flags"}, {25'd0, IRin, MARin, RYin, MDRread, busy, done, illegal}, {25'd0, fl});
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    if (busy) busy_cyc++;
  endtask

  task automatic fetch(input string tag, input logic [6:0] ill);
    busy_cyc = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    exp_cyc({tag, " T0"}, R19, R20, 32'd20, F_MAR | F_BUSY | ill);
    tick();
    exp_cyc({tag, " T1"}, R20 | R21, R19, 32'd0, F_MDR | F_BUSY | ill);
    tick();
    exp_cyc({tag, " T2"}, 32'd0, R21, 32'd0, F_IR | F_BUSY | ill);
  endtask

  task automatic shra_exec(input string tag, input logic [6:0] ill);
    tick();
    exp_cyc({tag, " T3"}, 32'd0, 32'h1, 32'd0, F_RY | F_BUSY | ill);
    tick();
    exp_cyc({tag, " T4"}, R19, 32'h10, 32'd11, F_BUSY | ill);
    tick();
    exp_cyc({tag, " T5"}, 32'h80, R19, 32'd0, F_BUSY | F_DONE | ill);
    tick();
    exp_cyc({tag, " idle"}, 32'd0, 32'd0, 32'd0, ill);
  endtask

  initial begin
    int d1, d2;
    repeat (2) @(posedge clock);
    #1;
    exp_cyc("reset", 32'd0, 32'd0, 32'd0, 7'd0);
    clear = 1'b1;

    ir = IR_SHRA;
    fetch("shra", 7'd0);
    shra_exec("shra", 7'd0);
    chk("shra len", busy_cyc, 6);

    ir = IR_SHRA;
    busy_cyc = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    mem_ready = 1'b0;
    exp_cyc("wait T0", R19, R20, 32'd20, F_MAR | F_BUSY);
    tick();
    exp_cyc("wait T1c1", R20 | R21, R19, 32'd0, F_MDR | F_BUSY);
    tick();
    exp_cyc("wait T1c2", R21, R19, 32'd0, F_MDR | F_BUSY);
    tick();
    exp_cyc("wait T1c3", R21, R19, 32'd0, F_MDR | F_BUSY);
    tick();
    mem_ready = 1'b1;
    exp_cyc("wait T1c4", R21, R19, 32'd0, F_MDR | F_BUSY);
    tick();
    exp_cyc("wait T2", 32'd0, R21, 32'd0, F_IR | F_BUSY);
    tick();
    alu_busy = 1'b1;
    exp_cyc("wait T3", 32'd0, 32'h1, 32'd0, F_RY | F_BUSY);
    tick();
    exp_cyc("wait T4c1", R19, 32'h10, 32'd11, F_BUSY);
    tick();
    exp_cyc("wait T4c2", R19, 32'h10, 32'd11, F_BUSY);
    tick();
    alu_busy = 1'b0;
    exp_cyc("wait T4c3", R19, 32'h10, 32'd11, F_BUSY);
    tick();
    exp_cyc("wait T5", 32'h80, R19, 32'd0, F_BUSY | F_DONE);
    tick();
    exp_cyc("wait idle", 32'd0, 32'd0, 32'd0, 7'd0);
    chk("wait len", busy_cyc, 11);

    ir = IR_MUL;
    fetch("mul", 7'd0);
    tick();
    exp_cyc("mul T3", 32'd0, 32'h8, 32'd0, F_RY | F_BUSY);
    tick();
    exp_cyc("mul T4", R19, 32'h20, 32'd15, F_BUSY);
    tick();
    exp_cyc("mul T5", R17, R19, 32'd0, F_BUSY);
    tick();
    exp_cyc("mul T6", R16, R18, 32'd0, F_BUSY | F_DONE);
    tick();
    exp_cyc("mul idle", 32'd0, 32'd0, 32'd0, 7'd0);
    chk("mul len", busy_cyc, 7);

    ir = IR_BAD;
    fetch("bad", 7'd0);
    tick();
    exp_cyc("bad T3", 32'd0, 32'd0, 32'd0, F_BUSY);
    tick();
    exp_cyc("bad idle", 32'd0, 32'd0, 32'd0, F_ILL);
    ir = IR_SHRA;
    fetch("post", F_ILL);
    shra_exec("post", F_ILL);
    chk("post len", busy_cyc, 6);

    halt = 1'b0;
    d1 = -1;
    d2 = -1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c < 30 && d2 < 0; c++) begin
      tick();
      chk("b2b busy", {31'd0, busy}, 32'd1);
      if (d1 >= 0 && c == d1 + 1) begin
        chk("b2b T0 Rout", Rout, R20);
        halt = 1'b1;
      end
      if (done) begin
        if (d1 < 0) d1 = c;
        else        d2 = c;
      end
    end
    chk("b2b first done", d1, 5);
    chk("b2b spacing", d2 - d1, 6);
    tick();
    chk("b2b end busy", {31'd0, busy}, 32'd0);

    ir = IR_SHRA;
    fetch("rst", F_ILL);
    tick();
    alu_busy = 1'b1;
    tick();
    exp_cyc("rst T4", R19, 32'h10, 32'd11, F_BUSY | F_ILL);
    #2 clear = 1'b0;
    #1;
    exp_cyc("rst mid", 32'd0, 32'd0, 32'd0, 7'd0);
    clear = 1'b1;
    alu_busy = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    exp_cyc("rst T0", R19, R20, 32'd20, F_MAR | F_BUSY);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
